// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : key_debouncer
//  Description : Debounces the active-low pushbutton into a level, press/
//                release/long-press pulses and a press-toggled enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int c_DW = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [c_DW-1:0] c_DCNT_LAST = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HW-1:0] c_HCNT_MAX  = c_HW'(LONG_PRESS_CYCLES);
  localparam logic [c_HW-1:0] c_HCNT_HIT  = c_HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [c_DW-1:0] r_dcnt;
  logic [c_HW-1:0] r_hcnt;

  logic            w_key_s;
  logic            w_dcnt_done;
  logic            w_long_hit;
  logic [c_HW-1:0] w_hcnt_next;

  assign w_key_s     = ~r_sync2;
  assign w_dcnt_done = (r_dcnt == c_DCNT_LAST);
  // Saturation at the limit is what stops a second long pulse for one press.
  assign w_hcnt_next = (r_hcnt == c_HCNT_MAX) ? r_hcnt : r_hcnt + 1'b1;
  assign w_long_hit  = (r_hcnt == c_HCNT_HIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= RELEASED;
      r_dcnt        <= '0;
      r_hcnt        <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      r_sync1       <= key_n;
      r_sync2       <= r_sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      case (r_state)
        RELEASED: begin
          if (w_key_s) begin
            r_state <= ARMING;
            r_dcnt  <= '0;
          end
        end

        ARMING: begin
          if (!w_key_s) begin
            r_state <= RELEASED;
            r_dcnt  <= '0;
          end else if (w_dcnt_done) begin
            r_state     <= HELD;
            press_pulse <= 1'b1;
            pressed     <= 1'b1;
            toggle      <= ~toggle;
            r_hcnt      <= '0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end

        HELD: begin
          r_hcnt     <= w_hcnt_next;
          long_pulse <= w_long_hit;
          if (!w_key_s) begin
            r_state <= DISARMING;
            r_dcnt  <= '0;
          end
        end

        DISARMING: begin
          r_hcnt <= w_hcnt_next;
          if (w_key_s) begin
            r_state    <= HELD;
            long_pulse <= w_long_hit;
          end else if (w_dcnt_done) begin
            // Release wins over a coincident long hit: no long pulse after release.
            r_state       <= RELEASED;
            release_pulse <= 1'b1;
            pressed       <= 1'b0;
          end else begin
            r_dcnt     <= r_dcnt + 1'b1;
            long_pulse <= w_long_hit;
          end
        end

        default: r_state <= RELEASED;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debouncer
//  Description : Directed vector bench for key_debouncer (D=4, L=20).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debouncer;

  localparam int c_D = 4;
  localparam int c_L = 20;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic key_n   = 1'b0;
  logic pressed, press_pulse, release_pulse, long_pulse, toggle;
  logic [4:0] outs;

  key_debouncer #(
    .DEBOUNCE_CYCLES  (c_D),
    .LONG_PRESS_CYCLES(c_L)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .toggle       (toggle)
  );

  always #5 clock = ~clock;

  always_comb outs = {pressed, press_pulse, release_pulse, long_pulse, toggle};

  typedef struct {
    logic       key;
    logic [4:0] exp;  // {pressed, press_pulse, release_pulse, long_pulse, toggle}
  } vec_t;

  vec_t vecs[24];

  int checks   = 0;
  int failures = 0;
  int stepno, n_press, n_rel, n_long, n_held, t_press, t_rel, t_long;
  logic [2:0] tseq;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear();
    stepno  = 0;
    n_press = 0;
    n_rel   = 0;
    n_long  = 0;
    n_held  = 0;
    t_press = -1;
    t_rel   = -1;
    t_long  = -1;
    tseq    = '0;
  endtask

  // One clock: drive key on the falling edge, observe 1 time unit after the rising edge.
  task automatic step(input logic k);
    @(negedge clock);
    key_n = k;
    @(posedge clock);
    #1;
    if (press_pulse) begin
      n_press++;
      t_press = stepno;
      tseq = {tseq[1:0], toggle};
    end
    if (release_pulse) begin
      n_rel++;
      t_rel = stepno;
    end
    if (long_pulse) begin
      n_long++;
      t_long = stepno;
    end
    if (pressed) n_held++;
    chk("pulse_mutex", int'(press_pulse) + int'(release_pulse) + int'(long_pulse) <= 1, 1);
    stepno++;
  endtask

  task automatic hold(input logic k, input int n);
    repeat (n) step(k);
  endtask

  task automatic do_reset();
    key_n   = 1'b1;
    reset_n = 1'b0;
    #1;
    @(posedge clock);
    #2 reset_n = 1'b1;
    hold(1'b1, 4);
    clear();
  endtask

  initial begin
    for (int i = 0; i < 24; i++) begin
      vecs[i].key = (i < 12) ? 1'b0 : 1'b1;
      vecs[i].exp = {(i >= 6 && i < 18), (i == 6), (i == 18), 1'b0, (i >= 6)};
    end

    // Reset with key held: outputs stay 0, then a full debounce after release.
    reset_n = 1'b0;
    key_n   = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("reset_outs", int'(outs), 0);
    end
    #2 reset_n = 1'b1;
    clear();
    hold(1'b0, 8);
    chk("rst_press_cnt", n_press, 1);
    chk("rst_press_time", t_press, 6);
    chk("rst_toggle", int'(toggle), 1);
    hold(1'b1, 10);
    chk("rst_release_cnt", n_rel, 1);
    chk("rst_pressed_after", int'(pressed), 0);

    // Clean press and release, cycle by cycle.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].key);
      chk($sformatf("vec%0d", i), int'(outs), int'(vecs[i].exp));
    end

    // Bounce: short lows are rejected, a long low is accepted once.
    clear();
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 3);
    hold(1'b1, 8);
    chk("bounce_press", n_press, 0);
    chk("bounce_release", n_rel, 0);
    chk("bounce_held", n_held, 0);
    hold(1'b0, 10);
    chk("bounce_then_press", n_press, 1);
    hold(1'b1, 10);
    chk("bounce_then_release", n_rel, 1);

    // Two-cycle high glitch while held.
    clear();
    hold(1'b0, 8);
    hold(1'b1, 2);
    hold(1'b0, 6);
    hold(1'b1, 10);
    chk("glitch_press", n_press, 1);
    chk("glitch_release", n_rel, 1);
    chk("glitch_release_time", t_rel, 22);
    chk("glitch_held_cycles", n_held, t_rel - t_press);
    chk("glitch_long", n_long, 0);

    // Long press.
    clear();
    hold(1'b0, 40);
    chk("long_cnt", n_long, 1);
    chk("long_delay", t_long - t_press, c_L);
    hold(1'b1, 10);
    chk("long_release", n_rel, 1);
    chk("long_cnt_after", n_long, 1);

    // Short press released before the long threshold.
    clear();
    hold(1'b0, 15);
    hold(1'b1, 30);
    chk("short_long", n_long, 0);
    chk("short_release", n_rel, 1);

    // Reset mid-press discards progress and yields a fresh press.
    clear();
    hold(1'b0, 10);
    reset_n = 1'b0;
    #1;
    chk("midreset_outs", int'(outs), 0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    clear();
    hold(1'b0, 10);
    chk("midreset_press_time", t_press, 6);
    chk("midreset_toggle", int'(toggle), 1);
    hold(1'b1, 10);

    // Toggle across three presses.
    do_reset();
    repeat (3) begin
      hold(1'b0, 10);
      hold(1'b1, 10);
    end
    chk("toggle_press_cnt", n_press, 3);
    chk("toggle_release_cnt", n_rel, 3);
    chk("toggle_seq", int'(tseq), 3'b101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debouncer.md
# key_debouncer

Cleans up the active-low board pushbutton (KEY[0]) and produces debounced levels, single-cycle event pulses, and a press-toggled enable bit. It sits directly upstream of the LED blink counter: `toggle` gates the blink, `press_pulse` can restart it, and `long_pulse` is free for mode changes. Runs on the 50 MHz board clock.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: cycles the synchronized key must hold stable to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 50000000: cycles after `press_pulse` before `long_pulse` fires (1 s); must be > `DEBOUNCE_CYCLES`.
- `clock` in 1: system clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `key_n` in 1: raw pushbutton, active-low, asynchronous to `clock`.
- `pressed` out 1: debounced level, 1 = button held.
- `press_pulse` out 1: one-cycle pulse on accepted press.
- `release_pulse` out 1: one-cycle pulse on accepted release.
- `long_pulse` out 1: one-cycle pulse, at most once per press.
- `toggle` out 1: flips on every accepted press; enable to blink counter.

## Operation
- Synchronizer: 2 flops on `key_n`, both reset to 1. `key_s` = inverted second flop (1 = pressed).
- Debounce counter `dcnt` is sized to hold `DEBOUNCE_CYCLES`-1. Hold counter `hcnt` is sized to hold `LONG_PRESS_CYCLES` and saturates there.
- FSM states:
  - RELEASED: `pressed`=0. `key_s`=1 → ARMING, `dcnt`←0.
  - ARMING:
    - `key_s`=0 → RELEASED, `dcnt`←0.
    - `key_s`=1 and `dcnt`=`DEBOUNCE_CYCLES`-1 → HELD. Register `press_pulse`=1 and `pressed`=1, flip `toggle`, `hcnt`←0.
    - Otherwise `dcnt`++.
  - HELD: `hcnt`++ (saturating). `key_s`=0 → DISARMING, `dcnt`←0.
  - DISARMING: `hcnt` keeps counting and `pressed` stays 1.
    - `key_s`=1 → HELD; `dcnt` is not reused.
    - `key_s`=0 and `dcnt`=`DEBOUNCE_CYCLES`-1 → RELEASED. Register `release_pulse`=1 and `pressed`=0.
    - Otherwise `dcnt`++.
- `long_pulse`=1 for the single cycle in which `hcnt` first reaches `LONG_PRESS_CYCLES` while in HELD or DISARMING. Saturation prevents any repeat for the same press.
- All outputs are registered. No combinational path from `key_n` to any output.

## Timing
- Reset (asynchronous assert, any time) forces:
  - sync flops = 1, state = RELEASED, `dcnt`=`hcnt`=0;
  - `pressed`=`press_pulse`=`release_pulse`=`long_pulse`=`toggle`=0.
- Reset mid-press: all progress is discarded. After deassert with the key still held, a full debounce occurs and a fresh `press_pulse` is generated.
- Press latency: `key_n` low first sampled at edge k and held → `press_pulse`/`pressed` go high after edge k+2+`DEBOUNCE_CYCLES`. Release latency is symmetric.
- `long_pulse` is high exactly `LONG_PRESS_CYCLES` cycles after the `press_pulse` cycle, provided the FSM has not returned to RELEASED.
- Any glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no pulse and no level change. Each bounce restarts `dcnt` from 0.
- `press_pulse`, `release_pulse` and `long_pulse` are mutually exclusive in any cycle.
- `long_pulse` cannot follow a `release_pulse` of the same press.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20.
- Reset: `reset_n`=0 with `key_n`=0 → all outputs 0 during reset. Release at edge r → `press_pulse` exactly once, after edge r+6; `toggle`=1.
- Clean press: `key_n` 1→0 sampled at edge 10 and held → `press_pulse` high only after edge 16; `pressed`=1 from then on; `toggle` 0→1.
- Bounce: `key_n` low 3 cycles, high 1, low 3, high → no pulses, `pressed`=0 throughout. Then low 10 cycles → exactly one `press_pulse`.
- Release: from held, `key_n`=1 held → `release_pulse` after 6 edges, `pressed`=0. A 2-cycle high glitch while held → no `release_pulse`, `pressed` stays 1.
- Long press: hold 40 cycles → `long_pulse` exactly once, 20 cycles after `press_pulse`. A release at 15 cycles → no `long_pulse`.
- Toggle: 3 clean presses → `toggle` sequence 1,0,1, with 3 `press_pulse` and 3 `release_pulse`.
